// File: rtl/or_unit_rr_arbiter_if.sv
// Handshake bundle for the shared OR unit: NREQ operand ports in, one result port out.
// The package carries the width helper shared by the interface and the arbiter.
package or_unit_rr_arbiter_pkg;
   function automatic int min_int(input int x, input int y);
      return (x < y) ? x : y;
   endfunction
endpackage

interface or_unit_rr_arbiter_if
   import or_unit_rr_arbiter_pkg::*;
#(
   parameter int A    = 16,
   parameter int B    = 8,
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int W    = min_int(A, B)
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*A-1:0] req_a;
   logic [NREQ*B-1:0] req_b;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_c;
   logic [IDW-1:0]    out_id;

   modport master (
      output req_valid, req_a, req_b, out_ready,
      input  req_ready, out_valid, out_c, out_id
   );

   modport slave (
      input  req_valid, req_a, req_b, out_ready,
      output req_ready, out_valid, out_c, out_id
   );
endinterface

// File: rtl/or_unit_rr_arbiter.sv
// Round-robin arbiter sharing one OR combine unit between NREQ requesters,
// with a single registered, pass-through result stage.
module or_unit_rr_arbiter
   import or_unit_rr_arbiter_pkg::*;
#(
   parameter int A    = 16,
   parameter int B    = 8,
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   or_unit_rr_arbiter_if.slave   arb,
   output logic [CNTW-1:0]       txn_count
);
   localparam int W = min_int(A, B);
   localparam logic [IDW:0] NL = (IDW+1)'(NREQ);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e          state_q;
   logic [W-1:0]    out_c_q;
   logic [IDW-1:0]  out_id_q;
   logic [IDW-1:0]  ptr_q;
   logic [CNTW-1:0] txn_q;

   logic              can_accept;
   logic              out_hs;
   logic              grant_en;
   logic              hit;
   logic [IDW-1:0]    gnt;
   logic [IDW-1:0]    ptr_d;
   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] shr;
   logic [NREQ-1:0]   rot;
   logic [NREQ-1:0]   onehot;
   logic [A-1:0]      a_sel;
   logic [B-1:0]      b_sel;
   logic [W-1:0]      c_d;

   assign out_hs     = (state_q == FULL) & arb.out_ready;
   assign can_accept = (state_q == EMPTY) | arb.out_ready;

   // Rotate the request vector so bit 0 is the requester at ptr.
   assign dbl = {arb.req_valid, arb.req_valid};
   assign shr = dbl >> ptr_q;
   assign rot = shr[NREQ-1:0];

   always_comb begin : pick
      logic [IDW:0] sum;
      sum = '0;
      hit = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            hit = 1'b1;
         end
      end
      if (sum >= NL) sum = sum - NL;
      gnt = sum[IDW-1:0];
   end

   always_comb begin : next_ptr
      logic [IDW:0] nx;
      nx = {1'b0, gnt} + (IDW+1)'(1);
      if (nx >= NL) nx = '0;
      ptr_d = nx[IDW-1:0];
   end

   assign grant_en      = can_accept & hit & ~rst;
   assign onehot        = NREQ'(1) << gnt;
   assign arb.req_ready = grant_en ? onehot : '0;

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt == IDW'(i)) begin
            a_sel = arb.req_a[i*A +: A];
            b_sel = arb.req_b[i*B +: B];
         end
      end
   end

   // Bits of either operand at or above W never reach the result.
   assign c_d = a_sel[W-1:0] | b_sel[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= EMPTY;
         out_c_q  <= '0;
         out_id_q <= '0;
         ptr_q    <= '0;
         txn_q    <= '0;
      end else begin
         if (grant_en) begin
            state_q  <= FULL;
            out_c_q  <= c_d;
            out_id_q <= gnt;
            ptr_q    <= ptr_d;
         end else if (out_hs) begin
            state_q  <= EMPTY;
         end
         if (out_hs) txn_q <= txn_q + 1'b1;
      end
   end

   assign arb.out_valid = (state_q == FULL);
   assign arb.out_c     = out_c_q;
   assign arb.out_id    = out_id_q;
   assign txn_count     = txn_q;
endmodule

// File: tb/tb_or_unit_rr_arbiter.sv
// Scoreboard bench for or_unit_rr_arbiter: a reference model predicts grants
// and results each cycle; a narrow-operand instance checks the result width.
module tb_or_unit_rr_arbiter;
   logic clk;
   logic rst;
   logic [7:0] txn;
   logic [7:0] txn2;

   or_unit_rr_arbiter_if #(.A(16), .B(8), .NREQ(4), .IDW(2)) bus ();
   or_unit_rr_arbiter_if #(.A(4),  .B(8), .NREQ(4), .IDW(2)) bus2 ();

   or_unit_rr_arbiter #(.A(16), .B(8), .NREQ(4), .IDW(2), .CNTW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .arb       (bus),
      .txn_count (txn)
   );

   or_unit_rr_arbiter #(.A(4), .B(8), .NREQ(4), .IDW(2), .CNTW(8)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .arb       (bus2),
      .txn_count (txn2)
   );

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] c;
   } exp_t;

   exp_t       sbq[$];
   int         id_log[$];
   logic [15:0] a_r[4];
   logic [7:0]  b_r[4];
   int         n_run;
   int         n_fail;
   bit         mon_en;
   bit         m_full;
   int         m_ptr;
   logic [7:0] m_txn;
   logic [3:0] rdy_acc;
   logic [7:0] hold_c;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*16 +: 16] = a_r[i];
         bus.req_b[i*8 +: 8]   = b_r[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_model();
      m_full = 1'b0;
      m_ptr  = 0;
      m_txn  = '0;
      sbq.delete();
      id_log.delete();
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      rst = 1'b1;
      flush_model();
      step();
      step();
      rst = 1'b0;
   endtask

   // Reference model, evaluated mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (mon_en && !rst) begin : mon
         exp_t       e;
         logic [3:0] er;
         bit         acc;
         int         g;
         chk("txn_count", txn, m_txn);
         chk("out_valid", bus.out_valid, m_full);
         if (bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("out_c", bus.out_c, e.c);
               chk("out_id", bus.out_id, e.id);
            end
            id_log.push_back(int'(bus.out_id));
         end
         er  = '0;
         acc = 1'b0;
         g   = 0;
         if (!m_full || bus.out_ready) begin
            for (int k = 0; k < 4; k++) begin
               if (!acc && bus.req_valid[(m_ptr + k) % 4]) begin
                  acc = 1'b1;
                  g   = (m_ptr + k) % 4;
               end
            end
         end
         if (acc) er[g] = 1'b1;
         chk("req_ready", bus.req_ready, er);
         if (m_full && bus.out_ready) m_txn = m_txn + 8'd1;
         if (acc) begin
            e.id = 2'(g);
            e.c  = a_r[g][7:0] | b_r[g];
            sbq.push_back(e);
            m_ptr  = (g + 1) % 4;
            m_full = 1'b1;
         end else if (m_full && bus.out_ready) begin
            m_full = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired tests=%0d", n_run);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp2[6];
      int exp4[4];
      exp2 = '{0, 1, 2, 3, 0, 1};
      exp4 = '{1, 3, 1, 3};
      n_run  = 0;
      n_fail = 0;
      mon_en = 1'b0;
      flush_model();
      for (int i = 0; i < 4; i++) begin
         a_r[i] = '0;
         b_r[i] = '0;
      end
      bus.out_ready  = 1'b0;
      bus.req_valid  = 4'hF;
      bus2.req_valid = '0;
      bus2.req_a     = '0;
      bus2.req_b     = '0;
      bus2.out_ready = 1'b1;
      rst = 1'b1;
      #3;
      chk("rst_ready", bus.req_ready, 4'h0);
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_txn", txn, 8'h00);
      step();
      step();
      bus.req_valid = '0;
      rst = 1'b0;
      mon_en = 1'b1;
      chk("rst_out_c", bus.out_c, 8'h00);
      chk("rst_out_id", bus.out_id, 2'd0);

      // single transaction from requester 0
      a_r[0] = 16'h00F0;
      b_r[0] = 8'h0F;
      bus.req_valid = 4'b0001;
      bus.out_ready = 1'b1;
      step();
      chk("t1_valid", bus.out_valid, 1'b1);
      chk("t1_c", bus.out_c, 8'hFF);
      chk("t1_id", bus.out_id, 2'd0);
      bus.req_valid = '0;
      step();
      chk("t1_txn", txn, 8'd1);

      // all requesters, back to back
      do_reset();
      bus.out_ready = 1'b1;
      bus.req_valid = 4'hF;
      for (int i = 0; i < 4; i++) begin
         a_r[i] = 16'($urandom);
         b_r[i] = 8'($urandom);
      end
      repeat (6) begin
         step();
         chk("t2_valid", bus.out_valid, 1'b1);
         for (int i = 0; i < 4; i++) begin
            a_r[i] = 16'($urandom);
            b_r[i] = 8'($urandom);
         end
      end
      bus.req_valid = '0;
      step();
      chk("t2_txn", txn, 8'd6);
      chk("t2_empty", bus.out_valid, 1'b0);
      chk("t2_cnt", id_log.size(), 6);
      for (int i = 0; i < 6 && i < id_log.size(); i++)
         chk("t2_seq", id_log[i], exp2[i]);

      // stall while full, then release with requester 2 waiting
      bus.out_ready = 1'b0;
      a_r[0] = 16'h1234;
      b_r[0] = 8'h40;
      bus.req_valid = 4'b0001;
      step();
      a_r[2] = 16'h0003;
      b_r[2] = 8'h50;
      bus.req_valid = 4'b0100;
      repeat (3) begin
         chk("t3_ready", bus.req_ready, 4'h0);
         chk("t3_hold_c", bus.out_c, 8'h74);
         chk("t3_hold_id", bus.out_id, 2'd0);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("t3_grant", bus.req_ready, 4'b0100);
      step();
      chk("t3_valid", bus.out_valid, 1'b1);
      chk("t3_id", bus.out_id, 2'd2);
      chk("t3_c", bus.out_c, 8'h53);
      bus.req_valid = '0;
      step();
      chk("t3_txn", txn, 8'd8);
      chk("t3_empty", bus.out_valid, 1'b0);

      // sparse requesters 1 and 3 from ptr 2
      do_reset();
      bus.out_ready = 1'b1;
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = 4'b1010;
      rdy_acc = '0;
      repeat (3) begin
         #1;
         rdy_acc = rdy_acc | bus.req_ready;
         step();
      end
      bus.req_valid = '0;
      step();
      chk("t4_ready_seen", rdy_acc, 4'b1010);
      chk("t4_cnt", id_log.size(), 4);
      for (int i = 0; i < 4 && i < id_log.size(); i++)
         chk("t4_seq", id_log[i], exp4[i]);

      // upper operand bits ignored; narrow operand instance
      a_r[0] = 16'hAA00;
      b_r[0] = 8'h00;
      bus.req_valid = 4'b0001;
      bus2.req_a[3:0] = 4'h5;
      bus2.req_b[7:0] = 8'hFA;
      bus2.req_valid  = 4'b0001;
      step();
      chk("t5_c", bus.out_c, 8'h00);
      chk("t5_n_c", {28'h0, bus2.out_c}, 32'h0000000F);
      chk("t5_n_id", bus2.out_id, 2'd0);
      bus.req_valid = '0;
      bus2.req_a[3:0] = 4'h3;
      bus2.req_b[7:0] = 8'hF0;
      step();
      chk("t5_n_c2", {28'h0, bus2.out_c}, 32'h00000003);
      bus2.req_valid = '0;

      // async reset while full and stalled, then counter wrap
      bus.out_ready = 1'b0;
      a_r[0] = 16'h0011;
      bus.req_valid = 4'b0001;
      step();
      #2;
      rst = 1'b1;
      flush_model();
      #1;
      chk("t6_valid", bus.out_valid, 1'b0);
      chk("t6_txn", txn, 8'd0);
      chk("t6_ready", bus.req_ready, 4'h0);
      chk("t6_c", bus.out_c, 8'h00);
      step();
      rst = 1'b0;
      bus.req_valid = 4'hF;
      bus.out_ready = 1'b1;
      repeat (256) step();
      bus.req_valid = '0;
      step();
      chk("t6_wrap", txn, 8'd0);
      chk("t6_drained", bus.out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
